// File: rtl/anton_neopixel_stream_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anton_neopixel_stream_receiver_pkg
// Description : Shared receiver definitions: state encoding, parameter
//               defaults and a constant-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package anton_neopixel_stream_receiver_pkg;

  // Receiver line states (2-bit encoding).
  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,
    RX_LOW  = 2'd1,
    RX_HIGH = 2'd2
  } rx_state_e;

  localparam int BUFFER_END_DEFAULT        = 255;
  // 50 us of low line at 7 MHz is the WS2812 latch time.
  localparam int RESET_DELAY_DEFAULT       = 350;
  localparam int RX_HIGH_THRESHOLD_DEFAULT = 4;
  localparam int RX_HIGH_MAX_DEFAULT       = 7;

  // Bits needed to hold values 0..value-1, never less than one bit so
  // that degenerate parameter choices still give legal vector widths.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/anton_neopixel_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : anton_neopixel_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line plus
//               an edge-detect flop producing single-cycle rise/fall pulses.
// Ports       : clk7mhz  - sampling clock
//               reset    - asynchronous active-high reset
//               async_in - raw line
//               sync_out - synchronized line (2 cycles after the pin)
//               rise     - sync_out went 0->1 this cycle
//               fall     - sync_out went 1->0 this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module anton_neopixel_rx_sync (
  input  logic clk7mhz,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk7mhz or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/anton_neopixel_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : anton_neopixel_stream_receiver
// Description : WS2812-style single-wire receiver. Measures each high pulse
//               to decode bits (MSB first), assembles 24-bit pixels with a
//               write strobe and buffer index, and detects the latch gap as
//               end of frame.
// Ports       : clk7mhz, reset           - clock, async active-high reset
//               stream_in                - raw serial line (asynchronous)
//               reg_ctrl_run             - enable; 0 holds the receiver in SYNC
//               reg_ctrl_32bit           - index step of 4 instead of 1
//               pixel_data/index/valid   - pixel write port
//               frame_done               - gap seen after at least one bit
//               synced                   - receiver has seen a full gap
//               err_pulse/partial/overrun- single-cycle error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module anton_neopixel_stream_receiver
  import anton_neopixel_stream_receiver_pkg::*;
#(
  parameter  int BUFFER_END     = BUFFER_END_DEFAULT,
  parameter  int RESET_DELAY    = RESET_DELAY_DEFAULT,
  parameter  int HIGH_THRESHOLD = RX_HIGH_THRESHOLD_DEFAULT,
  parameter  int HIGH_MAX       = RX_HIGH_MAX_DEFAULT,
  localparam int BUFFER_BITS    = clog2_min1(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   reset,
  input  logic                   stream_in,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_32bit,
  output logic [23:0]            pixel_data,
  output logic [BUFFER_BITS-1:0] pixel_index,
  output logic                   pixel_valid,
  output logic                   frame_done,
  output logic                   synced,
  output logic                   err_pulse,
  output logic                   err_partial,
  output logic                   err_overrun
);

  localparam int LOW_W  = clog2_min1(RESET_DELAY + 1);
  localparam int HIGH_W = clog2_min1(HIGH_MAX + 1);
  // Extra headroom so an index one step past BUFFER_END is representable
  // and can be detected as overrun instead of wrapping back into range.
  localparam int IDX_W  = BUFFER_BITS + 3;

  localparam logic [LOW_W-1:0]  LOW_GAP    = LOW_W'(RESET_DELAY);
  localparam logic [LOW_W-1:0]  LOW_LAST   = LOW_W'(RESET_DELAY - 1);
  localparam logic [HIGH_W-1:0] HIGH_LIMIT = HIGH_W'(HIGH_MAX);
  localparam logic [HIGH_W-1:0] HIGH_THR   = HIGH_W'(HIGH_THRESHOLD);
  localparam logic [IDX_W-1:0]  IDX_END    = IDX_W'(BUFFER_END);

  logic line, line_rise, line_fall;

  anton_neopixel_rx_sync u_sync (
    .clk7mhz (clk7mhz),
    .reset   (reset),
    .async_in(stream_in),
    .sync_out(line),
    .rise    (line_rise),
    .fall    (line_fall)
  );

  rx_state_e               state_q, state_d;
  logic [LOW_W-1:0]        low_cnt_q, low_cnt_d;
  logic [HIGH_W-1:0]       high_cnt_q, high_cnt_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [22:0]             shift_q, shift_d;
  logic                    got_bit_q, got_bit_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [23:0]             pixel_data_q, pixel_data_d;
  logic [BUFFER_BITS-1:0]  pixel_index_q, pixel_index_d;
  logic                    pixel_valid_q, pixel_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    err_partial_q, err_partial_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    bit_dec;
  logic [23:0]             shifted;

  always_comb begin
    state_d       = state_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    got_bit_d     = got_bit_q;
    wr_idx_d      = wr_idx_q;
    pixel_data_d  = pixel_data_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    err_pulse_d   = 1'b0;
    err_partial_d = 1'b0;
    err_overrun_d = 1'b0;
    bit_dec       = (high_cnt_q >= HIGH_THR);
    shifted       = {shift_q, bit_dec};

    if (!reg_ctrl_run) begin
      state_d    = RX_SYNC;
      low_cnt_d  = '0;
      high_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
      got_bit_d  = 1'b0;
      wr_idx_d   = '0;
    end else begin
      case (state_q)
        RX_SYNC: begin
          if (line) begin
            low_cnt_d = '0;
          end else if (low_cnt_q == LOW_LAST) begin
            state_d   = RX_LOW;
            low_cnt_d = '0;
          end else begin
            low_cnt_d = low_cnt_q + 1'b1;
          end
        end

        RX_LOW: begin
          if (low_cnt_q != LOW_GAP) low_cnt_d = low_cnt_q + 1'b1;
          // End of frame fires once, on the transition into saturation;
          // a coincident rise still enters HIGH below.
          if (low_cnt_q == LOW_LAST) begin
            frame_done_d  = got_bit_q;
            err_partial_d = (bit_cnt_q != 5'd0);
            bit_cnt_d     = '0;
            shift_d       = '0;
            got_bit_d     = 1'b0;
            wr_idx_d      = '0;
          end
          if (line_rise) begin
            state_d    = RX_HIGH;
            high_cnt_d = HIGH_W'(1);
          end
        end

        RX_HIGH: begin
          if (line_fall) begin
            state_d   = RX_LOW;
            low_cnt_d = '0;
            got_bit_d = 1'b1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              shift_d   = '0;
              if (wr_idx_q <= IDX_END) begin
                pixel_valid_d = 1'b1;
                pixel_data_d  = shifted;
                pixel_index_d = wr_idx_q[BUFFER_BITS-1:0];
                wr_idx_d      = wr_idx_q + (reg_ctrl_32bit ? IDX_W'(4) : IDX_W'(1));
              end else begin
                err_overrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shifted[22:0];
            end
          end else if (high_cnt_q == HIGH_LIMIT) begin
            // Over-long pulse: the stream is not trustworthy until the
            // next full gap, so drop everything and resynchronise.
            err_pulse_d = 1'b1;
            state_d     = RX_SYNC;
            low_cnt_d   = '0;
            high_cnt_d  = '0;
            bit_cnt_d   = '0;
            shift_d     = '0;
            got_bit_d   = 1'b0;
            wr_idx_d    = '0;
          end else begin
            high_cnt_d = high_cnt_q + 1'b1;
          end
        end

        default: state_d = RX_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk7mhz or posedge reset) begin
    if (reset) begin
      state_q       <= RX_SYNC;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      got_bit_q     <= 1'b0;
      wr_idx_q      <= '0;
      pixel_data_q  <= '0;
      pixel_index_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_partial_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      got_bit_q     <= got_bit_d;
      wr_idx_q      <= wr_idx_d;
      pixel_data_q  <= pixel_data_d;
      pixel_index_q <= pixel_index_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      err_pulse_q   <= err_pulse_d;
      err_partial_q <= err_partial_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_index = pixel_index_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign synced      = (state_q != RX_SYNC);
  assign err_pulse   = err_pulse_q;
  assign err_partial = err_partial_q;
  assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_anton_neopixel_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_anton_neopixel_stream_receiver
// Description : Directed self-checking bench. A cycle model derived from the
//               line behaviour (pulse lengths, gap timing) predicts every
//               output each cycle; literal expectations pin scenario results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_anton_neopixel_stream_receiver;

  localparam int BE   = 11;
  localparam int RD   = 20;
  localparam int TH   = 4;
  localparam int HMAX = 7;
  localparam int IDXW = 4;   // bits to address indices 0..11

  logic            clk7mhz = 1'b0;
  logic            reset = 1'b1;
  logic            stream_in = 1'b0;
  logic            reg_ctrl_run = 1'b1;
  logic            reg_ctrl_32bit = 1'b0;
  logic [23:0]     pixel_data;
  logic [IDXW-1:0] pixel_index;
  logic            pixel_valid, frame_done, synced;
  logic            err_pulse, err_partial, err_overrun;

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_stream_receiver #(
    .BUFFER_END    (BE),
    .RESET_DELAY   (RD),
    .HIGH_THRESHOLD(TH),
    .HIGH_MAX      (HMAX)
  ) dut (
    .clk7mhz       (clk7mhz),
    .reset         (reset),
    .stream_in     (stream_in),
    .reg_ctrl_run  (reg_ctrl_run),
    .reg_ctrl_32bit(reg_ctrl_32bit),
    .pixel_data    (pixel_data),
    .pixel_index   (pixel_index),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done),
    .synced        (synced),
    .err_pulse     (err_pulse),
    .err_partial   (err_partial),
    .err_overrun   (err_overrun)
  );

  int n_check = 0;
  int n_pass  = 0;

  // ---------------- behavioural model ----------------
  logic        m_p1 = 0, m_p2 = 0;     // pin seen 1 and 2 cycles ago
  bit          m_synced = 0;           // a full gap has been observed
  bit          m_in_pulse = 0;
  int          m_lowrun = 0;           // consecutive lows while unsynced
  int          m_since = 0;            // cycles since last fall / sync
  int          m_hl = 0;               // high samples in current pulse
  int          m_nbits = 0;
  bit          m_any = 0;
  logic [23:0] m_pend = 0;
  int          m_idx = 0;
  logic [23:0] e_data = 0;
  int          e_index = 0;
  bit          e_valid = 0, e_done = 0, e_perr = 0, e_part = 0, e_ovr = 0;

  task automatic model_clear_frame();
    m_nbits = 0; m_any = 0; m_pend = '0; m_idx = 0;
  endtask

  task automatic model_step();
    logic line;
    e_valid = 0; e_done = 0; e_perr = 0; e_part = 0; e_ovr = 0;
    if (reset) begin
      m_p1 = 0; m_p2 = 0; m_synced = 0; m_in_pulse = 0; m_lowrun = 0;
      m_since = 0; m_hl = 0; model_clear_frame(); e_data = '0; e_index = 0;
    end else begin
      line = m_p2;
      m_p2 = m_p1;
      m_p1 = stream_in;
      if (!reg_ctrl_run) begin
        m_synced = 0; m_in_pulse = 0; m_lowrun = 0; m_since = 0; m_hl = 0;
        model_clear_frame();
      end else if (!m_synced) begin
        if (line) m_lowrun = 0;
        else begin
          m_lowrun++;
          if (m_lowrun == RD) begin m_synced = 1; m_since = 0; m_lowrun = 0; end
        end
      end else if (m_in_pulse) begin
        if (!line) begin
          m_pend = {m_pend[22:0], (m_hl >= TH) ? 1'b1 : 1'b0};
          m_nbits++; m_any = 1; m_in_pulse = 0; m_since = 0;
          if (m_nbits == 24) begin
            if (m_idx <= BE) begin
              e_valid = 1; e_data = m_pend; e_index = m_idx;
              m_idx += reg_ctrl_32bit ? 4 : 1;
            end else e_ovr = 1;
            m_nbits = 0;
          end
        end else begin
          m_hl++;
          if (m_hl > HMAX) begin
            e_perr = 1; m_synced = 0; m_in_pulse = 0; m_lowrun = 0;
            model_clear_frame();
          end
        end
      end else begin
        m_since++;
        if (m_since == RD) begin
          e_done = m_any;
          e_part = (m_nbits != 0);
          model_clear_frame();
        end
        if (line) begin m_in_pulse = 1; m_hl = 1; end
      end
    end
  endtask

  // ---------------- checking ----------------
  int          cnt_valid = 0, cnt_done = 0, cnt_perr = 0, cnt_part = 0, cnt_ovr = 0;
  logic [23:0] pq_data[$];
  int          pq_idx[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  task automatic compare();
    logic [33:0] got, exp;
    got = {pixel_data, pixel_index, pixel_valid, frame_done, synced,
           err_pulse, err_partial, err_overrun};
    exp = {e_data, e_index[IDXW-1:0], e_valid, e_done, m_synced,
           e_perr, e_part, e_ovr};
    check("cycle", 64'(got), 64'(exp));
    if (pixel_valid) begin
      cnt_valid++; pq_data.push_back(pixel_data); pq_idx.push_back(int'(pixel_index));
    end
    if (frame_done)  cnt_done++;
    if (err_pulse)   cnt_perr++;
    if (err_partial) cnt_part++;
    if (err_overrun) cnt_ovr++;
  endtask

  task automatic clear_counts();
    cnt_valid = 0; cnt_done = 0; cnt_perr = 0; cnt_part = 0; cnt_ovr = 0;
    pq_data.delete(); pq_idx.delete();
  endtask

  task automatic tick();
    @(posedge clk7mhz);
    model_step();
    @(negedge clk7mhz);
    compare();
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic lvl, input int n);
    stream_in = lvl;
    repeat (n) tick();
  endtask

  task automatic send_raw(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_raw(5, 3);
    else   send_raw(2, 6);
  endtask

  task automatic send_pixel(input logic [23:0] px);
    for (int i = 23; i >= 0; i--) send_bit(px[i]);
  endtask

  task automatic gap();
    drive(1'b0, RD + 6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_synced", 64'(synced), 64'd0);
    check("reset_data",   64'(pixel_data), 64'd0);
    check("reset_valid",  64'(pixel_valid), 64'd0);

    // Power-up gate: a short gap does not sync, a full gap does
    clear_counts();
    drive(1'b1, 4);
    drive(1'b0, RD - 1);
    send_raw(5, 3);
    check("short_gap_synced", 64'(synced), 64'd0);
    drive(1'b0, RD);
    check("full_gap_synced", 64'(synced), 64'd1);
    check("gate_no_pixel", 64'(cnt_valid), 64'd0);

    // Single pixel
    clear_counts();
    send_pixel(24'hA5C33C);
    gap();
    check("px_count", 64'(cnt_valid), 64'd1);
    if (cnt_valid == 1) begin
      check("px_data", 64'(pq_data[0]), 64'hA5C33C);
      check("px_index", 64'(pq_idx[0]), 64'd0);
    end
    check("px_frame_done", 64'(cnt_done), 64'd1);
    check("px_no_partial", 64'(cnt_part), 64'd0);

    // Threshold: 4 -> '1', 3 -> '0', 7 still legal
    clear_counts();
    for (int i = 0; i < 24; i++) send_raw((i == 23) ? 7 : ((i % 2 == 0) ? 4 : 3), 4);
    gap();
    check("thr_count", 64'(cnt_valid), 64'd1);
    check("thr_data", 64'(pixel_data), 64'hAAAAAB);
    check("thr_index", 64'(pixel_index), 64'd0);

    // Over-long pulse
    clear_counts();
    send_raw(8, 5);
    check("perr_count", 64'(cnt_perr), 64'd1);
    check("perr_synced", 64'(synced), 64'd0);
    drive(1'b0, 2 * RD + 6);
    check("perr_resync", 64'(synced), 64'd1);
    check("perr_no_done", 64'(cnt_done + cnt_valid), 64'd0);

    // 32-bit index stepping and restart on next frame
    reg_ctrl_32bit = 1'b1;
    clear_counts();
    send_pixel(24'h111111);
    send_pixel(24'h222222);
    send_pixel(24'h333333);
    gap();
    check("m32_count", 64'(cnt_valid), 64'd3);
    if (cnt_valid == 3) begin
      check("m32_idx0", 64'(pq_idx[0]), 64'd0);
      check("m32_idx1", 64'(pq_idx[1]), 64'd4);
      check("m32_idx2", 64'(pq_idx[2]), 64'd8);
      check("m32_data1", 64'(pq_data[1]), 64'h222222);
    end
    clear_counts();
    send_pixel(24'h444444);
    gap();
    check("m32_restart", 64'(pixel_index), 64'd0);
    reg_ctrl_32bit = 1'b0;

    // Overrun: 13 pixels into 12 slots
    clear_counts();
    for (int p = 0; p < 13; p++) send_pixel(24'h5A0000 | 24'(p));
    gap();
    check("ovr_valid", 64'(cnt_valid), 64'd12);
    check("ovr_pulse", 64'(cnt_ovr), 64'd1);
    check("ovr_done", 64'(cnt_done), 64'd1);
    check("ovr_last_data", 64'(pixel_data), 64'h5A000B);
    for (int i = 0; i < cnt_valid; i++) check("ovr_index", 64'(pq_idx[i]), 64'(i));

    // Partial pixel
    clear_counts();
    for (int i = 0; i < 10; i++) send_bit(1'(i % 2));
    gap();
    check("part_pulse", 64'(cnt_part), 64'd1);
    check("part_done", 64'(cnt_done), 64'd1);
    check("part_no_pixel", 64'(cnt_valid), 64'd0);

    // Run disable drops pending bits silently
    clear_counts();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reg_ctrl_run = 1'b0;
    drive(1'b0, 3);
    check("run_off_synced", 64'(synced), 64'd0);
    reg_ctrl_run = 1'b1;
    gap();
    check("run_off_pulses", 64'(cnt_done + cnt_part), 64'd0);
    check("run_on_synced", 64'(synced), 64'd1);

    // Asynchronous reset mid-pixel, then a pixel with no preceding gap
    clear_counts();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    stream_in = 1'b0;
    reset = 1'b1;
    #1;
    check("areset_synced", 64'(synced), 64'd0);
    check("areset_data", 64'(pixel_data), 64'd0);
    check("areset_index", 64'(pixel_index), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    send_pixel(24'h123456);
    drive(1'b0, 2 * RD + 10);
    check("nogap_no_pixel", 64'(cnt_valid), 64'd0);
    check("nogap_no_done", 64'(cnt_done), 64'd0);
    check("nogap_synced", 64'(synced), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
`default_nettype wire
